// File: rtl/rgb2hsv_pkg.sv
// Shared constants, sector encoding and width helpers for the RGB->HSV pipeline.
package rgb2hsv_pkg;

  localparam int HUE_60  = 60;
  localparam int HUE_120 = 120;
  localparam int HUE_240 = 240;
  localparam int HUE_360 = 360;

  typedef enum logic [1:0] {
    SECT_R    = 2'd0,
    SECT_G    = 2'd1,
    SECT_B    = 2'd2,
    SECT_GREY = 2'd3
  } sect_e;

  typedef struct packed {
    sect_e sect;
    logic  neg;
  } hue_ctl_t;

  function automatic int latency(input int dw);
    return dw + 3;
  endfunction

  function automatic int hue_dvd_w(input int dw);
    return $clog2(HUE_60) + dw;
  endfunction

  function automatic int sat_dvd_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/rgb2hsv_div_pipe.sv
// Pipelined restoring divider: one compare/subtract stage per quotient bit, MSB first.
// Caller guarantees dividend < divisor << Q_W, so the remainder never needs extra headroom.
module div_pipe #(
  parameter int DVD_W = 14,
  parameter int DVS_W = 8,
  parameter int Q_W   = 8
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [DVD_W-1:0] dvd_i,
  input  logic [DVS_W-1:0] dvs_i,
  output logic             valid_o,
  output logic [Q_W-1:0]   quo_o
);

  localparam int CMP_W = (DVD_W > DVS_W + Q_W) ? DVD_W : DVS_W + Q_W;

  logic [DVD_W-1:0] rem_q [Q_W];
  logic [DVD_W-1:0] rem_s [Q_W];
  logic [DVD_W-1:0] rem_d [Q_W];
  logic [DVS_W-1:0] dvs_q [Q_W];
  logic [DVS_W-1:0] dvs_s [Q_W];
  logic [Q_W-1:0]   quo_q [Q_W];
  logic [Q_W-1:0]   quo_s [Q_W];
  logic [Q_W-1:0]   quo_d [Q_W];
  logic [CMP_W-1:0] sub_c [Q_W];
  logic [Q_W-1:0]   vld_pipe;

  always_comb begin
    rem_s[0] = dvd_i;
    dvs_s[0] = dvs_i;
    quo_s[0] = '0;
    for (int k = 1; k < Q_W; k++) begin
      rem_s[k] = rem_q[k-1];
      dvs_s[k] = dvs_q[k-1];
      quo_s[k] = quo_q[k-1];
    end
    for (int k = 0; k < Q_W; k++) begin
      // stage k resolves quotient bit Q_W-1-k
      sub_c[k] = CMP_W'(dvs_s[k]) << (Q_W - 1 - k);
      quo_d[k] = quo_s[k];
      rem_d[k] = rem_s[k];
      if (CMP_W'(rem_s[k]) >= sub_c[k]) begin
        rem_d[k]             = DVD_W'(CMP_W'(rem_s[k]) - sub_c[k]);
        quo_d[k][Q_W-1-k]    = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < Q_W; k++) begin
        rem_q[k] <= '0;
        dvs_q[k] <= '0;
        quo_q[k] <= '0;
      end
    end else begin
      vld_pipe <= {vld_pipe[Q_W-2:0], valid_i};
      for (int k = 0; k < Q_W; k++) begin
        rem_q[k] <= rem_d[k];
        dvs_q[k] <= dvs_s[k];
        quo_q[k] <= quo_d[k];
      end
    end
  end

  assign valid_o = vld_pipe[Q_W-1];
  assign quo_o   = quo_q[Q_W-1];

endmodule

// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB->HSV converter, latency DATA_W+3, no backpressure.
// Optional range-mask output enabled by defining RGB2HSV_THRESH_EN.
module rgb2hsv_pipe
  import rgb2hsv_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HUE_HALF = 1,
  parameter int HUE_W    = 9
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [3*DATA_W-1:0]       in_rgb,
  input  logic                      in_de,
  input  logic                      in_hsync,
  input  logic                      in_vsync,
`ifdef RGB2HSV_THRESH_EN
  input  logic [HUE_W-1:0]          th_h_lo,
  input  logic [HUE_W-1:0]          th_h_hi,
  input  logic [DATA_W-1:0]         th_s_lo,
  input  logic [DATA_W-1:0]         th_v_lo,
  output logic                      out_mask,
`endif
  output logic                      out_valid,
  output logic [HUE_W+2*DATA_W-1:0] out_hsv,
  output logic                      out_de,
  output logic                      out_hsync,
  output logic                      out_vsync
);

  localparam int LAT = latency(DATA_W);
  localparam int HDW = hue_dvd_w(DATA_W);
  localparam int SDW = sat_dvd_w(DATA_W);
  localparam logic [DATA_W-1:0] MAXV = '1;

  // stage 1
  logic [3*DATA_W-1:0] rgb_q;
  logic                vld_s1_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= '0;
      vld_s1_q <= 1'b0;
    end else begin
      rgb_q    <= in_rgb;
      vld_s1_q <= in_valid;
    end
  end

  // stage 2: sector decode and divider operands
  logic [DATA_W-1:0] r_c, g_c, b_c, mx_c, mn_c, delta_c, num_c;
  sect_e             sect_c;
  logic              neg_c;
  logic [HDW-1:0]    hdvd_d, hdvd_q;
  logic [SDW-1:0]    sdvd_d, sdvd_q;
  logic [DATA_W-1:0] hdvs_d, hdvs_q, sdvs_d, sdvs_q, v_q;
  hue_ctl_t          ctl_q;
  logic              vld_s2_q;

  assign r_c = rgb_q[3*DATA_W-1 -: DATA_W];
  assign g_c = rgb_q[2*DATA_W-1 -: DATA_W];
  assign b_c = rgb_q[DATA_W-1:0];

  always_comb begin
    sect_c = SECT_R;
    neg_c  = 1'b0;
    mx_c   = r_c;
    num_c  = '0;
    mn_c   = r_c;
    if (g_c < mn_c) mn_c = g_c;
    if (b_c < mn_c) mn_c = b_c;
    if (r_c >= g_c && r_c >= b_c) begin
      sect_c = SECT_R;
      mx_c   = r_c;
      if (g_c >= b_c) num_c = g_c - b_c;
      else begin num_c = b_c - g_c; neg_c = 1'b1; end
    end else if (g_c >= b_c) begin
      sect_c = SECT_G;
      mx_c   = g_c;
      if (b_c >= r_c) num_c = b_c - r_c;
      else begin num_c = r_c - b_c; neg_c = 1'b1; end
    end else begin
      sect_c = SECT_B;
      mx_c   = b_c;
      if (r_c >= g_c) num_c = r_c - g_c;
      else begin num_c = g_c - r_c; neg_c = 1'b1; end
    end
    delta_c = mx_c - mn_c;
    hdvs_d  = delta_c;
    sdvs_d  = mx_c;
    // grey: both dividers see 0/1 so no divide-by-zero reaches the pipeline
    if (delta_c == '0) begin
      sect_c = SECT_GREY;
      neg_c  = 1'b0;
      num_c  = '0;
      hdvs_d = DATA_W'(1);
      sdvs_d = DATA_W'(1);
    end
    hdvd_d = HDW'(num_c) * HDW'(HUE_60);
    sdvd_d = SDW'(delta_c) * SDW'(MAXV);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hdvd_q   <= '0;
      sdvd_q   <= '0;
      hdvs_q   <= '0;
      sdvs_q   <= '0;
      v_q      <= '0;
      ctl_q    <= '0;
      vld_s2_q <= 1'b0;
    end else begin
      hdvd_q   <= hdvd_d;
      sdvd_q   <= sdvd_d;
      hdvs_q   <= hdvs_d;
      sdvs_q   <= sdvs_d;
      v_q      <= mx_c;
      ctl_q    <= '{sect: sect_c, neg: neg_c};
      vld_s2_q <= vld_s1_q;
    end
  end

  // stages 3..DATA_W+2
  logic              vld_h, vld_s;
  logic [DATA_W-1:0] q_h, q_s;

  div_pipe #(.DVD_W(HDW), .DVS_W(DATA_W), .Q_W(DATA_W)) u_div_h (
    .pclk(pclk), .rst_n(rst_n), .valid_i(vld_s2_q), .dvd_i(hdvd_q), .dvs_i(hdvs_q),
    .valid_o(vld_h), .quo_o(q_h)
  );

  div_pipe #(.DVD_W(SDW), .DVS_W(DATA_W), .Q_W(DATA_W)) u_div_s (
    .pclk(pclk), .rst_n(rst_n), .valid_i(vld_s2_q), .dvd_i(sdvd_q), .dvs_i(sdvs_q),
    .valid_o(vld_s), .quo_o(q_s)
  );

  hue_ctl_t          ctl_sr [DATA_W];
  logic [DATA_W-1:0] v_sr   [DATA_W];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DATA_W; k++) begin
        ctl_sr[k] <= '0;
        v_sr[k]   <= '0;
      end
    end else begin
      ctl_sr[0] <= ctl_q;
      v_sr[0]   <= v_q;
      for (int k = 1; k < DATA_W; k++) begin
        ctl_sr[k] <= ctl_sr[k-1];
        v_sr[k]   <= v_sr[k-1];
      end
    end
  end

  // final stage
  logic [9:0]       base_c, qh10_c, hdeg_c;
  logic [HUE_W-1:0] hue_c;
  hue_ctl_t         ctl_c;

  assign ctl_c  = ctl_sr[DATA_W-1];
  assign qh10_c = 10'(q_h);

  always_comb begin
    base_c = '0;
    unique case (ctl_c.sect)
      SECT_R:  base_c = ctl_c.neg ? 10'(HUE_360) : 10'd0;
      SECT_G:  base_c = 10'(HUE_120);
      SECT_B:  base_c = 10'(HUE_240);
      default: base_c = '0;
    endcase
    hdeg_c = ctl_c.neg ? base_c - qh10_c : base_c + qh10_c;
    if (hdeg_c == 10'(HUE_360)) hdeg_c = '0;
    hue_c = (HUE_HALF != 0) ? HUE_W'(hdeg_c >> 1) : HUE_W'(hdeg_c);
  end

  logic                      out_valid_q;
  logic [HUE_W+2*DATA_W-1:0] out_hsv_q;
  logic [LAT-1:0][2:0]       sync_pipe;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_hsv_q   <= '0;
      sync_pipe   <= '0;
    end else begin
      out_valid_q <= vld_h & vld_s;
      out_hsv_q   <= {hue_c, q_s, v_sr[DATA_W-1]};
      sync_pipe   <= {sync_pipe[LAT-2:0], {in_de, in_hsync, in_vsync}};
    end
  end

`ifdef RGB2HSV_THRESH_EN
  logic hue_ok_c, mask_d, out_mask_q;

  always_comb begin
    if (th_h_lo <= th_h_hi) hue_ok_c = (hue_c >= th_h_lo) && (hue_c <= th_h_hi);
    else                    hue_ok_c = (hue_c >= th_h_lo) || (hue_c <= th_h_hi);
    mask_d = vld_h && vld_s && hue_ok_c && (q_s >= th_s_lo) && (v_sr[DATA_W-1] >= th_v_lo);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) out_mask_q <= 1'b0;
    else        out_mask_q <= mask_d;
  end

  assign out_mask = out_mask_q;
`endif

  assign out_valid = out_valid_q;
  assign out_hsv   = out_hsv_q;
  assign out_de    = sync_pipe[LAT-1][2];
  assign out_hsync = sync_pipe[LAT-1][1];
  assign out_vsync = sync_pipe[LAT-1][0];

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Bench: two converters (8-bit half-hue, 12-bit degree hue) against a floating-free HSV model.
module tb_rgb2hsv_pipe;

  localparam int LAT8  = 11;
  localparam int LAT12 = 15;

  logic pclk = 1'b0;
  logic rst_n;
  logic in_valid, in_de, in_hsync, in_vsync;
  logic [23:0] rgb8;
  logic [35:0] rgb12;

  logic        v8, de8, hs8, vs8;
  logic [24:0] hsv8;
  logic        v12, de12, hs12, vs12;
  logic [32:0] hsv12;

  logic [8:0]  th_h_lo = 9'd170, th_h_hi = 9'd10;
  logic [7:0]  th_s8 = 8'd50, th_v8 = 8'd50;
  logic [11:0] th_s12 = 12'd800, th_v12 = 12'd800;
  logic        m8, m12;

  always #5 pclk = ~pclk;

  rgb2hsv_pipe #(.DATA_W(8), .HUE_HALF(1), .HUE_W(9)) dut8 (
    .pclk(pclk), .rst_n(rst_n), .in_valid(in_valid), .in_rgb(rgb8),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
`ifdef RGB2HSV_THRESH_EN
    .th_h_lo(th_h_lo), .th_h_hi(th_h_hi), .th_s_lo(th_s8), .th_v_lo(th_v8), .out_mask(m8),
`endif
    .out_valid(v8), .out_hsv(hsv8), .out_de(de8), .out_hsync(hs8), .out_vsync(vs8)
  );

  rgb2hsv_pipe #(.DATA_W(12), .HUE_HALF(0), .HUE_W(9)) dut12 (
    .pclk(pclk), .rst_n(rst_n), .in_valid(in_valid), .in_rgb(rgb12),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
`ifdef RGB2HSV_THRESH_EN
    .th_h_lo(th_h_lo), .th_h_hi(th_h_hi), .th_s_lo(th_s12), .th_v_lo(th_v12), .out_mask(m12),
`endif
    .out_valid(v12), .out_hsv(hsv12), .out_de(de12), .out_hsync(hs12), .out_vsync(vs12)
  );

  typedef struct {
    bit     valid, de, hs, vs, m8, m12;
    longint hsv8, hsv12;
  } exp_t;

  exp_t hist [32];
  int   checks = 0, failures = 0, cyc = 0;

  // directed vectors for the 8-bit / half-hue instance
  int dr [8] = '{255,   0,   0, 255, 255, 100, 0, 200};
  int dg [8] = '{  0, 255,   0,   0, 255, 100, 0, 180};
  int db [8] = '{  0,   0, 255, 128,   0, 100, 0, 180};
  int dh [8] = '{  0,  60, 120, 165,  30,   0, 0,   0};
  int ds [8] = '{255, 255, 255, 255, 255,   0, 0,  25};
  int dv [8] = '{255, 255, 255, 255, 255, 100, 0, 200};
  int dm [8] = '{  1,   0,   0,   0,   0,   0, 0,   0};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic longint ref_hsv(input int dw, input bit half, input int r, input int g, input int b);
    int mx, mn, d, h, s;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn; h = 0; s = 0;
    if (d != 0) begin
      if (mx == r)      h = (g >= b) ? (60*(g-b))/d       : 360 - (60*(b-g))/d;
      else if (mx == g) h = (b >= r) ? 120 + (60*(b-r))/d : 120 - (60*(r-b))/d;
      else              h = (r >= g) ? 240 + (60*(r-g))/d : 240 - (60*(g-r))/d;
      if (h == 360) h = 0;
      s = (((1 << dw) - 1) * d) / mx;
    end
    if (half) h = h / 2;
    return (longint'(h) << (2*dw)) | (longint'(s) << dw) | longint'(mx);
  endfunction

  function automatic bit ref_mask(input longint hsv, input int dw, input int lo, input int hi,
                                  input int slo, input int vlo);
    longint h, s, v, m;
    m = (longint'(1) << dw) - 1;
    h = hsv >> (2*dw); s = (hsv >> dw) & m; v = hsv & m;
    if (s < slo || v < vlo) return 1'b0;
    if (lo <= hi) return (h >= lo) && (h <= hi);
    return (h >= lo) || (h <= hi);
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 32; i++) hist[i] = '{default: 0};
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_v8"}, 64'(v8), 64'd0);
    chk({tag, "_hsv8"}, 64'(hsv8), 64'd0);
    chk({tag, "_sync8"}, 64'({de8, hs8, vs8}), 64'd0);
    chk({tag, "_v12"}, 64'(v12), 64'd0);
    chk({tag, "_hsv12"}, 64'(hsv12), 64'd0);
    chk({tag, "_sync12"}, 64'({de12, hs12, vs12}), 64'd0);
`ifdef RGB2HSV_THRESH_EN
    chk({tag, "_mask"}, 64'({m8, m12}), 64'd0);
`endif
  endtask

  // one pixel clock: check what aged out, then drive and record the next input
  task automatic step(input bit rs, input bit v, input int di);
    exp_t e;
    int   r, g, b, r2, g2, b2, sel;
    @(negedge pclk);
    e = hist[(cyc - LAT8) & 31];
    chk("valid8", 64'(v8), 64'(e.valid));
    chk("sync8", 64'({de8, hs8, vs8}), 64'({e.de, e.hs, e.vs}));
    if (e.valid) chk("hsv8", 64'(hsv8), 64'(e.hsv8));
`ifdef RGB2HSV_THRESH_EN
    chk("mask8", 64'(m8), 64'(e.m8));
`endif
    e = hist[(cyc - LAT12) & 31];
    chk("valid12", 64'(v12), 64'(e.valid));
    chk("sync12", 64'({de12, hs12, vs12}), 64'({e.de, e.hs, e.vs}));
    if (e.valid) chk("hsv12", 64'(hsv12), 64'(e.hsv12));
`ifdef RGB2HSV_THRESH_EN
    chk("mask12", 64'(m12), 64'(e.m12));
`endif

    r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
    r2 = $urandom_range(0, 4095); g2 = $urandom_range(0, 4095); b2 = $urandom_range(0, 4095);
    sel = $urandom_range(0, 7);
    if (sel == 0) begin g = r; b = r; g2 = r2; b2 = r2; end
    else if (sel == 1) begin g = r; g2 = r2; end
    else if (sel == 2) begin b = g; r2 = 4095; end
    if (di >= 0) begin r = dr[di]; g = dg[di]; b = db[di]; end

    rst_n    = rs;
    in_valid = v;
    in_de    = 1'($urandom_range(0, 1));
    in_hsync = 1'($urandom_range(0, 1));
    in_vsync = 1'($urandom_range(0, 1));
    rgb8     = {8'(r), 8'(g), 8'(b)};
    rgb12    = {12'(r2), 12'(g2), 12'(b2)};

    e = '{default: 0};
    if (rs) begin
      e.valid = v; e.de = in_de; e.hs = in_hsync; e.vs = in_vsync;
      e.hsv8  = (di >= 0) ? ((longint'(dh[di]) << 16) | (longint'(ds[di]) << 8) | longint'(dv[di]))
                          : ref_hsv(8, 1'b1, r, g, b);
      e.hsv12 = ref_hsv(12, 1'b0, r2, g2, b2);
      e.m8    = v && ((di >= 0) ? (dm[di] != 0) : ref_mask(e.hsv8, 8, 170, 10, 50, 50));
      e.m12   = v && ref_mask(e.hsv12, 12, 170, 10, 800, 800);
    end
    hist[cyc & 31] = e;
    cyc++;
  endtask

  initial begin
    clear_hist();
    rst_n = 1'b1; in_valid = 1'b0; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
    rgb8 = '0; rgb12 = '0;
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("por");
    repeat (3) step(1'b0, 1'b1, -1);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, i);
      step(1'b1, 1'b0, -1);
    end
    repeat (1500) step(1'b1, $urandom_range(0, 3) != 0, -1);

    // reset with five pixels in flight
    repeat (5) step(1'b1, 1'b1, -1);
    #2 rst_n = 1'b0;
    clear_hist();
    #1 chk_reset_outputs("midrst");
    repeat (3) step(1'b0, 1'b1, -1);
    repeat (4) step(1'b1, 1'b0, -1);

    repeat (1500) step(1'b1, $urandom_range(0, 3) != 0, -1);
    repeat (20) step(1'b1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
